// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction at a time, reads operands from an
// internal 8x8 register file, drives the ALU, then writes back or resolves a branch.
module alu_issue_ctrl #(
  parameter int EXEC_WAIT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic [7:0] OPCODE,
  input  logic [2:0] DEST,
  input  logic [2:0] SRC1,
  input  logic [2:0] SRC2,
  input  logic [7:0] IMM,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO,
  output logic       DONE,
  output logic       BRANCH_TAKEN,
  input  logic [2:0] DBG_ADDR,
  output logic [7:0] DBG_DATA
);

  localparam int CW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_WAIT - 1);

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      op_q, op_d;
  logic [2:0]      dest_q, dest_d;
  logic [2:0]      src1_q, src1_d;
  logic [2:0]      src2_q, src2_d;
  logic [7:0]      imm_q, imm_d;
  logic [7:0]      d1_q, d1_d;
  logic [7:0]      d2_q, d2_d;
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      res_q, res_d;
  logic            done_q, done_d;
  logic            br_q, br_d;
  logic [7:0]      rf_q [8];
  logic [7:0]      rf_d [8];

  // Two's complement negate with 8-bit wrap; 0x80 maps to itself.
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return (~v) + 8'd1;
  endfunction

  function automatic logic writes_reg(input logic [7:0] op);
    return (op == OP_LOADI) || (op == OP_MOV) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Next-state, operand drive and write-back decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    imm_d   = imm_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    sel_d   = sel_q;
    res_d   = res_q;
    done_d  = 1'b0;
    br_d    = 1'b0;
    rf_d    = rf_q;

    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          op_d    = OPCODE;
          dest_d  = DEST;
          src1_d  = SRC1;
          src2_d  = SRC2;
          imm_d   = IMM;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        d1_d  = 8'h00;
        d2_d  = 8'h00;
        sel_d = SEL_FWD;
        case (op_q)
          OP_LOADI: d2_d = imm_q;
          OP_MOV:   d2_d = rf_q[src2_q];
          OP_ADD: begin
            d1_d  = rf_q[src1_q];
            d2_d  = rf_q[src2_q];
            sel_d = SEL_ADD;
          end
          OP_SUB, OP_BEQ: begin
            d1_d  = rf_q[src1_q];
            d2_d  = neg8(rf_q[src2_q]);
            sel_d = SEL_ADD;
          end
          OP_AND: begin
            d1_d  = rf_q[src1_q];
            d2_d  = rf_q[src2_q];
            sel_d = SEL_AND;
          end
          OP_OR: begin
            d1_d  = rf_q[src1_q];
            d2_d  = rf_q[src2_q];
            sel_d = SEL_OR;
          end
          default: begin
            d1_d  = 8'h00;
            d2_d  = 8'h00;
            sel_d = SEL_FWD;
          end
        endcase
        cnt_d   = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // The last wait cycle samples the settled ALU outputs and arms the DONE pulse.
        if (cnt_q == CNT_LAST) begin
          res_d   = ALU_RESULT;
          done_d  = 1'b1;
          br_d    = (op_q == OP_BEQ) ? ALU_ZERO : (op_q == OP_J);
          cnt_d   = '0;
          state_d = ST_WB;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_EXEC;
        end
      end
      ST_WB: begin
        if (writes_reg(op_q)) begin
          rf_d[dest_q] = res_q;
        end else begin
          rf_d = rf_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 8'h00;
      dest_q  <= 3'd0;
      src1_q  <= 3'd0;
      src2_q  <= 3'd0;
      imm_q   <= 8'h00;
      d1_q    <= 8'h00;
      d2_q    <= 8'h00;
      sel_q   <= SEL_FWD;
      res_q   <= 8'h00;
      done_q  <= 1'b0;
      br_q    <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      imm_q   <= imm_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      done_q  <= done_d;
      br_q    <= br_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign INSTR_READY  = (state_q == ST_IDLE) && !RESET;
  assign ALU_DATA1    = d1_q;
  assign ALU_DATA2    = d2_q;
  assign ALU_SELECT   = sel_q;
  assign DONE         = done_q;
  assign BRANCH_TAKEN = br_q;
  assign DBG_DATA     = rf_q[DBG_ADDR];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU, a branch/latency scoreboard
// checked by an independent DONE monitor, and register checks through DBG.
module tb_alu_issue_ctrl;
  localparam int W = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic [7:0] OPCODE;
  logic [2:0] DEST, SRC1, SRC2;
  logic [7:0] IMM;
  logic [7:0] ALU_DATA1, ALU_DATA2;
  logic [2:0] ALU_SELECT;
  logic [7:0] ALU_RESULT;
  logic       ALU_ZERO;
  logic       DONE, BRANCH_TAKEN;
  logic [2:0] DBG_ADDR;
  logic [7:0] DBG_DATA;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic exp_br_q [$];
  int   acc_q    [$];

  alu_issue_ctrl #(.EXEC_WAIT(W)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .OPCODE(OPCODE), .DEST(DEST), .SRC1(SRC1), .SRC2(SRC2), .IMM(IMM),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO), .DONE(DONE),
    .BRANCH_TAKEN(BRANCH_TAKEN), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU the controller talks to.
  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
    ALU_ZERO = (ALU_RESULT == 8'h00);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Record the cycle of every accepted handshake.
  always @(posedge CLK) begin
    if (INSTR_VALID && INSTR_READY) begin
      acc_q.push_back(cyc);
      n_acc++;
    end
    cyc <= cyc + 1;
  end

  // Monitor: every DONE pulse retires the oldest expected instruction.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (exp_br_q.size() == 0 || acc_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        check("branch_taken", int'(BRANCH_TAKEN), int'(exp_br_q.pop_front()));
        check("done_latency", cyc - acc_q.pop_front(), 2 + W);
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (INSTR_READY) return;
    end
    check("ready_timeout", int'(INSTR_READY), 1);
    $display("FAIL ready_timeout: controller never returned to idle");
    $fatal(1);
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] imm, input logic br);
    wait_ready();
    OPCODE = op; DEST = d; SRC1 = s1; SRC2 = s2; IMM = imm;
    INSTR_VALID = 1'b1;
    exp_br_q.push_back(br);
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
  endtask

  task automatic run(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                     input logic [2:0] s2, input logic [7:0] imm, input logic br);
    drive(op, d, s1, s2, imm, br);
    wait_ready();
  endtask

  task automatic reg_is(input string name, input logic [2:0] a, input logic [7:0] exp);
    DBG_ADDR = a;
    #1 check(name, int'(DBG_DATA), int'(exp));
  endtask

  initial begin
    RESET = 1'b1; INSTR_VALID = 1'b0; OPCODE = 8'h00; DEST = 3'd0; SRC1 = 3'd0;
    SRC2 = 3'd0; IMM = 8'h00; DBG_ADDR = 3'd0;
    #1 check("ready_in_reset", int'(INSTR_READY), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset_ready", int'(INSTR_READY), 1);
    check("reset_done", int'(DONE), 0);
    check("reset_data1", int'(ALU_DATA1), 0);
    check("reset_sel", int'(ALU_SELECT), 0);
    for (int i = 0; i < 8; i++) reg_is("reset_reg", 3'(i), 8'h00);

    // Basic loads and add.
    run(8'd0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0);
    run(8'd0, 3'd2, 3'd0, 3'd0, 8'h03, 1'b0);
    run(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0);
    reg_is("r1_loadi", 3'd1, 8'h05);
    reg_is("r2_loadi", 3'd2, 8'h03);
    reg_is("r3_add", 3'd3, 8'h08);

    // sub both ways, and, or.
    run(8'd3, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0);
    run(8'd3, 3'd5, 3'd2, 3'd1, 8'h00, 1'b0);
    run(8'd4, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0);
    run(8'd5, 3'd7, 3'd1, 3'd2, 8'h00, 1'b0);
    reg_is("r4_sub", 3'd4, 8'h02);
    reg_is("r5_sub_neg", 3'd5, 8'hFE);
    reg_is("r6_and", 3'd6, 8'h01);
    reg_is("r7_or", 3'd7, 8'h07);

    // Branches never write registers.
    run(8'd7, 3'd4, 3'd1, 3'd1, 8'h00, 1'b1);
    run(8'd7, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0);
    run(8'd6, 3'd6, 3'd0, 3'd0, 8'h00, 1'b1);
    reg_is("r4_after_br", 3'd4, 8'h02);
    reg_is("r5_after_br", 3'd5, 8'hFE);
    reg_is("r6_after_j", 3'd6, 8'h01);

    // Wrap-around, mov into r0, DEST==SRC, and 0x80 negation.
    run(8'd0, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b0);
    run(8'd0, 3'd2, 3'd0, 3'd0, 8'h01, 1'b0);
    run(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0);
    reg_is("add_7f_01", 3'd3, 8'h80);
    run(8'd0, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b0);
    run(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0);
    reg_is("add_ff_01", 3'd3, 8'h00);
    run(8'd1, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0);
    reg_is("mov_r0", 3'd0, 8'hFF);
    run(8'd2, 3'd2, 3'd2, 3'd2, 8'h00, 1'b0);
    reg_is("dest_eq_src", 3'd2, 8'h02);
    run(8'd0, 3'd4, 3'd0, 3'd0, 8'h80, 1'b0);
    run(8'd3, 3'd5, 3'd4, 3'd4, 8'h00, 1'b0);
    reg_is("sub_80_80", 3'd5, 8'h00);
    run(8'd7, 3'd0, 3'd4, 3'd4, 8'h00, 1'b1);

    // Reset during EXEC aborts the add.
    run(8'd0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0);
    drive(8'd2, 3'd3, 3'd1, 3'd1, 8'h00, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    exp_br_q.delete();
    acc_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    #1 check("ready_after_reset", int'(INSTR_READY), 1);
    reg_is("r3_aborted", 3'd3, 8'h00);
    reg_is("r1_cleared", 3'd1, 8'h00);
    repeat (6) @(negedge CLK);

    // Valid held high for 10 edges: two accepts.
    wait_ready();
    OPCODE = 8'd6; DEST = 3'd0; SRC1 = 3'd0; SRC2 = 3'd0; IMM = 8'h00;
    exp_br_q.push_back(1'b1);
    exp_br_q.push_back(1'b1);
    begin
      int base;
      base = n_acc;
      INSTR_VALID = 1'b1;
      repeat (10) @(posedge CLK);
      #1 INSTR_VALID = 1'b0;
      check("held_valid_accepts", n_acc - base, 2);
    end
    wait_ready();

    // Undefined opcode retires without a write.
    run(8'd0, 3'd1, 3'd0, 3'd0, 8'h55, 1'b0);
    run(8'hFF, 3'd1, 3'd2, 3'd2, 8'h11, 1'b0);
    reg_is("undef_no_write", 3'd1, 8'h55);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_br_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
